// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration between m0 (fetch) and m1 (load/store),
// SETUP/ACCESS sequencing toward the decoder, and an ACCESS-phase watchdog that turns a hung slave into an error.
module apb_master_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m0_write,
  input  logic [3:0]            m0_stb,
  output logic                  m0_done,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m1_write,
  input  logic [3:0]            m1_stb,
  output logic                  m1_done,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  output logic                  psel,
  output logic                  penable,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  perr,
  output logic                  grant,
  output logic [1:0]            o_state
);

  // Requester handshake: a requester holds req and its inputs stable until its one-cycle done pulse;
  // the transfer is accepted only in IDLE, and a req still high in the IDLE after done is a new request.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pdata;
  logic                  r_pwrite;
  logic [3:0]            r_pstb;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_grant;
  logic                  r_last_grant;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic                  w_req_any;
  logic                  w_pick;
  logic [CW-1:0]         w_cnt_next;
  logic                  w_timeout;
  logic                  w_resp;

  always_comb begin
    w_next_state = r_state;
    w_req_any    = m0_req | m1_req;
    w_cnt_next   = r_cnt + CW'(1);
    w_timeout    = (TIMEOUT_CYCLES != 0) && (w_cnt_next == TO_VAL);
    // Only one requester: it wins. Both: the one that did not win last time.
    if (m0_req && m1_req) w_pick = ~r_last_grant;
    else                  w_pick = m1_req;
    case (r_state)
      S_IDLE:   if (w_req_any) w_next_state = S_SETUP;
      S_SETUP:  w_next_state = S_ACCESS;
      S_ACCESS: if (pready || w_timeout) w_next_state = S_RESP;
      S_RESP:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_paddr      <= '0;
      r_pdata      <= '0;
      r_pwrite     <= 1'b0;
      r_pstb       <= '0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_paddr      <= w_pick ? m1_addr  : m0_addr;
            r_pdata      <= w_pick ? m1_wdata : m0_wdata;
            r_pwrite     <= w_pick ? m1_write : m0_write;
            r_pstb       <= w_pick ? m1_stb   : m0_stb;
            r_psel       <= 1'b1;
            r_penable    <= 1'b0;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
        end
        S_ACCESS: begin
          if (pready) begin
            r_rdata   <= prdata;
            r_err     <= perr;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
          end else if (TIMEOUT_CYCLES != 0) begin
            // The counter never wraps: reaching the limit leaves ACCESS on this edge.
            r_cnt <= w_cnt_next;
            if (w_timeout) begin
              r_rdata   <= '0;
              r_err     <= 1'b1;
              r_psel    <= 1'b0;
              r_penable <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign w_resp   = (r_state == S_RESP);
  assign m0_done  = w_resp & ~r_grant;
  assign m1_done  = w_resp & r_grant;
  assign m0_rdata = m0_done ? r_rdata : '0;
  assign m1_rdata = m1_done ? r_rdata : '0;
  assign m0_err   = m0_done & r_err;
  assign m1_err   = m1_done & r_err;

  assign paddr   = r_paddr;
  assign pdata   = r_pdata;
  assign pwrite  = r_pwrite;
  assign pstb    = r_pstb;
  assign psel    = r_psel;
  assign penable = r_penable;
  assign grant   = r_grant;
  assign o_state = r_state;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: inputs change and outputs are checked on the falling edge.
module tb_apb_master_arbiter;

  logic        pclk;
  logic        rst;
  logic        m0_req, m0_write, m0_done, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_stb;
  logic        m1_req, m1_write, m1_done, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_stb;
  logic [31:0] paddr, pdata, prdata;
  logic        pwrite, psel, penable, pready, perr, grant;
  logic [3:0]  pstb;
  logic [1:0]  o_state;

  int total = 0;
  int bad   = 0;

  apb_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .pclk(pclk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_write(m0_write), .m0_stb(m0_stb),
    .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_write(m1_write), .m1_stb(m1_stb),
    .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .paddr(paddr), .pdata(pdata), .pwrite(pwrite), .pstb(pstb), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .perr(perr), .grant(grant), .o_state(o_state)
  );

  // Clock / reset
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // Driver / check tasks
  task automatic cyc();
    @(negedge pclk);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_addr = '0; m0_wdata = '0; m0_write = 0; m0_stb = 4'hF;
    m1_req = 0; m1_addr = '0; m1_wdata = '0; m1_write = 0; m1_stb = 4'hF;
    prdata = '0; pready = 0; perr = 0;
  endtask

  initial begin
    logic [31:0] a_hold, d_hold;
    rst = 1'b1;
    idle_inputs();
    cyc();
    // Reset state
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_m0_done", m0_done, 0);
    chk("rst_m1_done", m1_done, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_grant", grant, 0);
    chk("rst_state", o_state, 0);
    rst = 1'b0;
    cyc();

    // Single read from m0, zero wait states
    m0_req = 1; m0_addr = 32'h8000_0010; pready = 1; prdata = 32'hDEAD_BEEF;
    cyc();
    chk("rd_setup_psel", psel, 1);
    chk("rd_setup_penable", penable, 0);
    chk("rd_setup_paddr", paddr, 32'h8000_0010);
    chk("rd_setup_grant", grant, 0);
    chk("rd_setup_pwrite", pwrite, 0);
    cyc();
    chk("rd_access_psel", psel, 1);
    chk("rd_access_penable", penable, 1);
    chk("rd_access_m0_done", m0_done, 0);
    cyc();
    chk("rd_m0_done", m0_done, 1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("rd_m0_err", m0_err, 0);
    chk("rd_m1_done", m1_done, 0);
    chk("rd_resp_psel", psel, 0);
    m0_req = 0;
    cyc();
    chk("rd_after_done", m0_done, 0);
    chk("rd_after_rdata", m0_rdata, 0);
    chk("rd_after_state", o_state, 0);

    // m1 write with three wait states
    m1_req = 1; m1_addr = 32'h1000_0000; m1_wdata = 32'h41; m1_stb = 4'h1; m1_write = 1;
    pready = 0; prdata = '0;
    cyc();
    chk("wr_setup_psel", psel, 1);
    chk("wr_setup_grant", grant, 1);
    chk("wr_setup_pwrite", pwrite, 1);
    cyc();
    chk("wr_access_penable", penable, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("wr_wait_paddr", paddr, 32'h1000_0000);
      chk("wr_wait_pdata", pdata, 32'h41);
      chk("wr_wait_pstb", pstb, 4'h1);
      chk("wr_wait_penable", penable, 1);
      chk("wr_wait_m1_done", m1_done, 0);
    end
    pready = 1;
    cyc();
    chk("wr_m1_done", m1_done, 1);
    chk("wr_m1_err", m1_err, 0);
    chk("wr_m0_done", m0_done, 0);
    m1_req = 0; m1_write = 0; m1_stb = 4'hF;
    cyc();

    // Round robin from reset with both requesters continuously asserted
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    m0_req = 1; m0_addr = 32'h100;
    m1_req = 1; m1_addr = 32'h200;
    pready = 1;
    for (int i = 0; i < 4; i++) begin
      logic exp_g;
      exp_g = i[0];
      cyc();
      chk("rr_grant", grant, exp_g);
      chk("rr_paddr", paddr, exp_g ? 32'h200 : 32'h100);
      prdata = 32'h1000 + i;
      cyc();
      cyc();
      chk("rr_m0_done", m0_done, !exp_g);
      chk("rr_m1_done", m1_done, exp_g);
      chk("rr_rdata", exp_g ? m1_rdata : m0_rdata, 32'h1000 + i);
      cyc();
      chk("rr_idle_psel", psel, 0);
    end
    m0_req = 0; m1_req = 0;
    cyc();

    // Decode error returned with data
    m0_req = 1; m0_addr = 32'h3000_0000; pready = 1; perr = 1; prdata = 32'h0BAD_C0DE;
    cyc();
    cyc();
    cyc();
    chk("derr_m0_done", m0_done, 1);
    chk("derr_m0_err", m0_err, 1);
    chk("derr_m0_rdata", m0_rdata, 32'h0BAD_C0DE);
    m0_req = 0; perr = 0;
    cyc();
    chk("derr_err_clear", m0_err, 0);

    // Watchdog timeout with pready held low
    m0_req = 1; m0_addr = 32'h40; pready = 0; perr = 1; prdata = 32'hFFFF_FFFF;
    cyc();
    cyc();
    a_hold = paddr;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("to_wait_psel", psel, 1);
      chk("to_wait_penable", penable, 1);
      chk("to_wait_done", m0_done, 0);
    end
    chk("to_wait_paddr", a_hold, 32'h40);
    cyc();
    chk("to_psel_drop", psel, 0);
    chk("to_penable_drop", penable, 0);
    chk("to_m0_done", m0_done, 1);
    chk("to_m0_err", m0_err, 1);
    chk("to_m0_rdata", m0_rdata, 0);
    m0_req = 0; perr = 0;
    cyc();

    // Asynchronous reset while in ACCESS
    m1_req = 1; m1_addr = 32'h500; pready = 0;
    cyc();
    cyc();
    chk("ar_pre_penable", penable, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_psel", psel, 0);
    chk("ar_penable", penable, 0);
    chk("ar_m1_done", m1_done, 0);
    chk("ar_state", o_state, 0);
    m0_req = 1; m0_addr = 32'h600; pready = 1; prdata = 32'h1234_5678;
    cyc();
    rst = 1'b0;
    cyc();
    chk("ar_grant_m0", grant, 0);
    chk("ar_paddr", paddr, 32'h600);
    cyc();
    cyc();
    d_hold = m0_rdata;
    chk("ar_m0_done", m0_done, 1);
    chk("ar_m1_done_after", m1_done, 0);
    chk("ar_m0_rdata", d_hold, 32'h1234_5678);
    m0_req = 0;
    cyc();
    cyc();
    chk("ar_m1_next", grant, 1);
    m1_req = 0;
    cyc();
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
Arbitrates the single APB master port between two CPU-side requesters: m0 (instruction fetch) and m1 (load/store). It sequences the APB SETUP and ACCESS phases toward the address decoder/peripheral mux, and returns read data and error per requester. Round-robin fairness prevents either requester from starving the other. An ACCESS-phase watchdog converts a hung slave into a bus error.

Parameters:
ADDR_WIDTH, 32, width of paddr and requester addresses
DATA_WIDTH, 32, width of read and write data
TIMEOUT_CYCLES, 255, ACCESS-phase wait cycles with pready=0 before abort; 0 disables the watchdog

Ports:
pclk  input  1  clock; one clock domain, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
m0_req  input  1  m0 request; held high with all m0 inputs stable until m0_done
m0_addr  input  ADDR_WIDTH  m0 address
m0_wdata  input  DATA_WIDTH  m0 write data
m0_write  input  1  m0 write(1)/read(0)
m0_stb  input  4  m0 byte strobes
m0_done  output  1  one-cycle completion pulse to m0
m0_rdata  output  DATA_WIDTH  m0 read data, valid while m0_done=1
m0_err  output  1  m0 error, valid while m0_done=1
m1_req, m1_addr, m1_wdata, m1_write, m1_stb, m1_done, m1_rdata, m1_err  same directions, widths and meaning for m1
paddr  output  ADDR_WIDTH  APB address, registered
pdata  output  DATA_WIDTH  APB write data, registered
pwrite  output  1  APB direction, registered
pstb  output  4  APB byte strobes, registered
psel  output  1  APB select, registered
penable  output  1  APB enable, registered
prdata  input  DATA_WIDTH  APB read data from decoder
pready  input  1  APB ready from decoder
perr  input  1  APB error from decoder
grant  output  1  requester owning the current transfer (0=m0, 1=m1); valid when state is not IDLE

Behaviour:
- Reset: all outputs 0; state=IDLE; last_grant=1, so m0 wins the first simultaneous request; watchdog counter=0. Reset mid-transfer aborts immediately: psel and penable drop, and no done pulse is issued.
- States: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE: with no req, stay. With one req, grant that requester. With both, grant the requester != last_grant.
  - On the grant edge: latch that requester's addr/wdata/write/stb into paddr/pdata/pwrite/pstb; set grant; set last_grant; psel=1, penable=0; go to SETUP.
- SETUP: exactly one cycle. Next edge sets penable=1 and goes to ACCESS; counter cleared.
- ACCESS: psel=penable=1; paddr/pdata/pwrite/pstb held stable.
  - pready=1: capture rdata=prdata and err=perr into the granted requester's outputs; psel=penable=0; go to RESP.
  - pready=0 and TIMEOUT_CYCLES!=0: increment the counter. When the counter reaches TIMEOUT_CYCLES, err=1, rdata=0, psel=penable=0, go to RESP.
  - perr is ignored while pready=0.
- RESP: granted requester's done=1 for this single cycle; the other requester's done stays 0; next state IDLE.
  - Requester must drop req, or present a new request, on the edge after done.
  - A req still high in the following IDLE cycle counts as a new request.
- rdata/err outputs are don't-care outside done; drive rdata=0 and err=0 when done=0.
- Minimum latency: req seen in IDLE at cycle N gives psel at N+1, penable at N+2, done at N+3 when pready=1 at N+2. Each added wait cycle adds 1.
- Back-to-back: minimum 4 cycles per transfer; psel is low for at least 2 cycles (RESP and IDLE) between transfers.
- Request changes while not IDLE have no effect on the in-flight transfer.
- Counter width: clog2(TIMEOUT_CYCLES+1), minimum 1 bit; no wrap, because it saturates into RESP.

Test Plan:
- Single read: m0_req, addr=0x80000010, pready=1 on first ACCESS, prdata=0xDEADBEEF -> psel at +1, penable at +2, m0_done at +3 with m0_rdata=0xDEADBEEF, m0_err=0, m1_done=0.
- Write with wait states: m1 write addr=0x10000000, wdata=0x41, stb=0x1, pready low 3 cycles -> paddr/pdata/pstb stable through ACCESS; m1_done 6 cycles after req; pwrite=1.
- Round-robin: m0 and m1 held continuously requesting from reset -> grant sequence 0,1,0,1; each done pulse goes only to the matching requester.
- Decode error: m0 read addr=0x30000000, decoder returns pready=1, perr=1 -> m0_done with m0_err=1, m0_rdata=0xBADC0DE captured as presented (err is the signal of record).
- Timeout: TIMEOUT_CYCLES=4, pready held 0 -> after 4 ACCESS cycles psel/penable drop, next cycle done=1, err=1, rdata=0.
- Async reset in ACCESS: assert rst mid-cycle -> psel, penable, done drop immediately without a clock edge; after release, a pending m1 and m0 pair is granted m0 first.
